fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage core. Owns the PC, drives the instruction bus with a valid/data_ok handshake, and delivers {valid, pc, instr} to ID. Obeys the load-use stall controls (PCWrite, IF_ID_Write) from hazard detection and the branch/jump redirect from EX. A fetched word that cannot enter ID is parked in a one-entry buffer, so stalls never re-fetch.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
// A request stays asserted with a stable address until iresp_data_ok completes it.
interface fetch_stage_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, issues instruction
// requests, parks one word across stalls and drains in-flight requests on redirect.
module fetch_stage #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          PCWrite,
  input  logic          IF_ID_Write,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  fetch_stage_if.master ibus,
  output logic          if_valid,
  output logic [63:0]   if_pc,
  output logic [31:0]   if_instr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_BUF   = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        ireq_valid_q, ireq_valid_d;
  logic        advance_s;

  assign advance_s = PCWrite && IF_ID_Write;

  // Next-state and register-update logic for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_instr_d = buf_instr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (ibus.iresp_data_ok) begin
          if (redirect_valid) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
          end else if (advance_s) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = ibus.iresp_data;
            pc_d       = pc_q + 64'd4;
          end else begin
            buf_instr_d = ibus.iresp_data;
            state_d     = S_BUF;
          end
        end else if (redirect_valid) begin
          pend_pc_d  = redirect_pc;
          if_valid_d = 1'b0;
          state_d    = S_DROP;
        end else if (IF_ID_Write) begin
          if_valid_d = 1'b0;
        end else begin
          if_valid_d = if_valid_q;
        end
      end
      S_BUF: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          state_d    = S_FETCH;
        end else if (advance_s) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = buf_instr_q;
          pc_d       = pc_q + 64'd4;
          state_d    = S_FETCH;
        end else begin
          state_d = S_BUF;
        end
      end
      S_DROP: begin
        // The old request must complete before the latest redirect target is fetched.
        if (IF_ID_Write) begin
          if_valid_d = 1'b0;
        end else begin
          if_valid_d = if_valid_q;
        end
        if (redirect_valid) begin
          pend_pc_d  = redirect_pc;
          if_valid_d = 1'b0;
        end else begin
          pend_pc_d = pend_pc_q;
        end
        if (ibus.iresp_data_ok) begin
          pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
          state_d = S_FETCH;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ireq_valid_d = (state_d == S_FETCH) || (state_d == S_DROP);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      pend_pc_q    <= 64'd0;
      buf_instr_q  <= 32'd0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 64'd0;
      if_instr_q   <= 32'd0;
      ireq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      buf_instr_q  <= buf_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      ireq_valid_q <= ireq_valid_d;
    end
  end

  assign ibus.ireq_valid = ireq_valid_q;
  assign ibus.ireq_addr  = pc_q;
  assign if_valid        = if_valid_q;
  assign if_pc           = if_pc_q;
  assign if_instr        = if_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a variable-latency memory and random
// stalls/redirects, checked every cycle against a transaction-level model.
module tb_fetch_stage;
  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        PCWrite = 1'b0;
  logic        IF_ID_Write = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  fetch_stage_if ibus ();

  fetch_stage #(.PC_RESET(PC_RESET)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ibus           (ibus),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the stage is doing, as the rules describe it.
  bit          m_idle;       // first cycle after reset, no request yet
  bit          m_parked;     // a fetched word waits for the pipeline
  bit          m_dropping;   // outstanding request will be discarded
  logic [31:0] m_park;
  logic [63:0] m_pend;
  logic [63:0] m_pc;
  bit          m_ifv;
  logic [63:0] m_ifpc;
  logic [31:0] m_ifinstr;

  int mem_wait;
  int mem_lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[26:2], 7'h13};
  endfunction

  task automatic model_reset();
    m_idle     = 1'b1;
    m_parked   = 1'b0;
    m_dropping = 1'b0;
    m_park     = 32'd0;
    m_pend     = 64'd0;
    m_pc       = PC_RESET;
    m_ifv      = 1'b0;
    m_ifpc     = 64'd0;
    m_ifinstr  = 32'd0;
    mem_wait   = 0;
    mem_lat    = 0;
  endtask

  task automatic model_step(input bit adv, input bit wr, input bit redir,
                            input logic [63:0] rpc, input bit ok, input logic [31:0] rdata);
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_parked) begin
      if (redir) begin
        m_parked = 1'b0; m_pc = rpc; m_ifv = 1'b0;
      end else if (adv) begin
        m_ifv = 1'b1; m_ifpc = m_pc; m_ifinstr = m_park;
        m_pc = m_pc + 64'd4; m_parked = 1'b0;
      end
    end else if (m_dropping) begin
      if (wr) m_ifv = 1'b0;
      if (redir) begin m_pend = rpc; m_ifv = 1'b0; end
      if (ok) begin m_pc = m_pend; m_dropping = 1'b0; end
    end else begin
      if (ok) begin
        if (redir) begin
          m_pc = rpc; m_ifv = 1'b0;
        end else if (adv) begin
          m_ifv = 1'b1; m_ifpc = m_pc; m_ifinstr = rdata; m_pc = m_pc + 64'd4;
        end else begin
          m_park = rdata; m_parked = 1'b1;
        end
      end else if (redir) begin
        m_pend = rpc; m_ifv = 1'b0; m_dropping = 1'b1;
      end else if (wr) begin
        m_ifv = 1'b0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("ireq_valid", {63'd0, ibus.ireq_valid}, {63'd0, !m_idle && !m_parked});
    check("ireq_addr", ibus.ireq_addr, m_pc);
    check("if_valid", {63'd0, if_valid}, {63'd0, m_ifv});
    check("if_pc", if_pc, m_ifpc);
    check("if_instr", {32'd0, if_instr}, {32'd0, m_ifinstr});
  endtask

  // One cycle at a negedge: check, drive fresh inputs, advance the model, wait.
  task automatic one_cycle(input int max_lat, input int stall_pct, input int redir_pct);
    bit          adv, redir, ok;
    logic [63:0] rpc;
    logic [31:0] rdata;
    compare_outputs();
    adv   = ($urandom_range(99) >= stall_pct);
    redir = !m_idle && ($urandom_range(99) < redir_pct);
    if ($urandom_range(9) == 0)
      rpc = 64'hFFFF_FFFF_FFFF_FFF8;
    else
      rpc = PC_RESET + 64'($urandom_range(4095)) * 64'd4;
    ok = 1'b0;
    if (ibus.ireq_valid) begin
      if (mem_wait >= mem_lat) begin
        ok = 1'b1; mem_wait = 0; mem_lat = $urandom_range(max_lat);
      end else begin
        mem_wait++;
      end
    end
    rdata = ok ? mem_word(ibus.ireq_addr) : 32'hDEAD_BEEF;
    PCWrite             = adv;
    IF_ID_Write         = adv;
    redirect_valid      = redir;
    redirect_pc         = redir ? rpc : 64'd0;
    ibus.iresp_data_ok  = ok;
    ibus.iresp_data     = rdata;
    model_step(adv, adv, redir, rpc, ok, rdata);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ireq_valid"}, {63'd0, ibus.ireq_valid}, 64'd0);
    check({tag, "_ireq_addr"}, ibus.ireq_addr, PC_RESET);
    check({tag, "_if_valid"}, {63'd0, if_valid}, 64'd0);
    check({tag, "_if_pc"}, if_pc, 64'd0);
    check({tag, "_if_instr"}, {32'd0, if_instr}, 64'd0);
  endtask

  initial begin
    ibus.iresp_data_ok = 1'b0;
    ibus.iresp_data    = 32'd0;
    model_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;

    // Zero-wait streaming, no hazards.
    repeat (12) one_cycle(0, 0, 0);
    // Stalls with zero-wait memory exercise the parking buffer.
    repeat (60) one_cycle(0, 50, 0);
    // Slow memory with redirects exercises the drop path.
    repeat (200) one_cycle(3, 20, 25);
    // Mixed traffic.
    repeat (3000) one_cycle($urandom_range(3), 30, 12);

    // Reset asynchronously while a word is parked.
    begin
      int i;
      for (i = 0; i < 400; i++) begin
        if (m_parked) break;
        one_cycle(0, 60, 0);
      end
      check("reach_parked", {63'd0, m_parked}, 64'd1);
    end
    compare_outputs();
    #2 resetn = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    PCWrite = 1'b0; IF_ID_Write = 1'b0; redirect_valid = 1'b0;
    ibus.iresp_data_ok = 1'b0;
    @(negedge clk);
    check_reset_values("held_reset");
    resetn = 1'b1;
    repeat (10) one_cycle(0, 0, 0);
    repeat (1000) one_cycle($urandom_range(3), 30, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
